// File: rtl/frame_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_mem_pkg
// Brief    : Shared types and default constants for the frame-buffer arbiter
//            and the edge-detection stage engines that share the RAM.
// Revision : 1.0
// ============================================================================
package frame_mem_pkg;

  // Arbiter states: waiting for a requester, or serving one owner's burst
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Defaults shared with the stage engines
  localparam int unsigned FM_NUM_REQ   = 5;
  localparam int unsigned FM_ADDR_W    = 16;
  localparam int unsigned FM_DATA_W    = 8;
  localparam int unsigned FM_MAX_BURST = 16;

endpackage
`default_nettype wire

// File: rtl/frame_mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin winner search. Scans the request vector
//            upward from the pointer, wrapping, and reports the first hit.
// Revision : 1.0
// ============================================================================
module rr_picker #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_winner
);

  // First set request at or after the pointer, modulo NUM_REQ
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && i_req[IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ)]) begin
        o_valid  = 1'b1;
        o_winner = IDX_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/frame_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : frame_mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port frame RAM between the
//            stage engines. Grants bounded bursts, one bubble between owners,
//            and steers 1-cycle read data back via a registered valid tag.
// Revision : 1.0
// ============================================================================
module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int NUM_REQ   = 5,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_enable,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_accept,
  output logic [NUM_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_mem_en,
  output logic                        o_mem_we,
  output logic [ADDR_W-1:0]           o_mem_addr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  input  logic [DATA_W-1:0]           i_mem_rdata,
  output logic                        o_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         r_state,     w_state_nxt;
  logic [IDX_W-1:0]   r_owner,     w_owner_nxt;
  logic [IDX_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
  logic [NUM_REQ-1:0] r_gnt,       w_gnt_nxt;
  logic [NUM_REQ-1:0] r_rvalid,    w_rvalid_nxt;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_own_req;
  logic               w_own_we;
  logic [ADDR_W-1:0]  w_own_addr;
  logic [DATA_W-1:0]  w_own_wdata;
  logic [IDX_W-1:0]   w_owner_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req    (i_req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick_idx)
  );

  // Owner's request fields; everyone else's fields are never looked at
  always_comb begin
    w_own_req   = i_req[r_owner];
    w_own_we    = i_req_we[r_owner];
    w_own_addr  = i_req_addr[int'(r_owner)*ADDR_W +: ADDR_W];
    w_own_wdata = i_req_wdata[int'(r_owner)*DATA_W +: DATA_W];
    w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  end

  // Next-state, burst accounting and RAM port drive
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_gnt_nxt       = r_gnt;
    w_rvalid_nxt    = '0;
    o_accept        = '0;
    o_mem_en        = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_addr      = '0;
    o_mem_wdata     = '0;
    case (r_state)
      ARB_IDLE: begin
        if (i_enable && w_pick_valid) begin
          w_state_nxt             = ARB_GRANT;
          w_owner_nxt             = w_pick_idx;
          w_burst_cnt_nxt         = '0;
          w_gnt_nxt               = '0;
          w_gnt_nxt[w_pick_idx]   = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (w_own_req) begin
          o_accept[r_owner]     = 1'b1;
          o_mem_en              = 1'b1;
          o_mem_we              = w_own_we;
          o_mem_addr            = w_own_addr;
          o_mem_wdata           = w_own_wdata;
          w_rvalid_nxt[r_owner] = !w_own_we;
          w_burst_cnt_nxt       = r_burst_cnt + CNT_W'(1);
          // Last allowed access of the burst closes the grant
          if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            w_state_nxt  = ARB_IDLE;
            w_gnt_nxt    = '0;
            w_rr_ptr_nxt = w_owner_inc;
          end
        end else begin
          // Owner went quiet: hand the RAM back
          w_state_nxt  = ARB_IDLE;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = w_owner_inc;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rvalid    <= w_rvalid_nxt;
    end
  end

  assign o_gnt    = r_gnt;
  assign o_busy   = (r_state == ARB_GRANT);
  assign o_owner  = r_owner;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = i_mem_rdata;

endmodule
`default_nettype wire

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Shares one single-port frame-buffer RAM between the edge-detection stage engines (gaussian, sobel, suppression, threshold, hysteresis). Each engine raises a request with its address, write enable and write data. The arbiter grants one owner at a time for a bounded burst of accesses, using round-robin fairness. It drives the RAM port and routes 1-cycle-latency read data back to the engine that issued the read.

## Interface
- NUM_REQ, 5: number of requesting engines (2..8)
- ADDR_W, 16: RAM address width
- DATA_W, 8: pixel width
- MAX_BURST, 16: maximum accepted accesses per grant (1..255)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  permits new grants; low does not abort a grant in progress
- req  in  NUM_REQ  per-engine access request, level
- req_we  in  NUM_REQ  per-engine write enable (1=write)
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, engine i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  registered one-hot grant
- accept  out  NUM_REQ  access of engine i is taken this cycle
- rvalid  out  NUM_REQ  read data valid for engine i
- rdata  out  DATA_W  read data, shared by all engines (= mem_rdata)
- mem_en, mem_we  out  1  RAM strobe / write
- mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en with mem_we=0
- busy  out  1  grant active;  owner  out  $clog2(NUM_REQ)  current/last owner index

## Operation
- State machine with two states:
  - ARB_IDLE: if enable and req≠0, pick the winner, load owner, set gnt, clear burst_cnt, go to ARB_GRANT.
  - ARB_GRANT: each cycle with req[owner]=1, accept[owner]=1 and mem_* carry the owner's fields (mem_en=1). burst_cnt increments per accept.
- Release from ARB_GRANT to ARB_IDLE:
  - when req[owner]=0 (no access that cycle), or
  - when the accept takes burst_cnt to MAX_BURST.
  - On release: gnt→0 next cycle and rr_ptr←(owner+1) mod NUM_REQ.
- Round-robin: the winner is the first set req bit scanning upward from rr_ptr, wrapping around.
- rvalid: a read accept at cycle N asserts rvalid[owner at N] at N+1, from a registered tag. This holds even if the grant was released at N.
- Outside accepts: mem_en=0, mem_we=0, mem_addr/mem_wdata=0, accept=0.
- enable low during ARB_GRANT: the burst continues to release normally; no new grant is issued afterwards.
- req_we/addr/wdata of non-owners are ignored.

## Timing
- Reset values: gnt=0, busy=0, owner=0, rvalid=0, mem_en=mem_we=0, mem_addr=mem_wdata=0. Internal state: state=ARB_IDLE, rr_ptr=0, burst_cnt=0.
- Reset mid-burst: outputs return to reset values asynchronously. A pending rvalid is dropped.
- Grant latency: req high at cycle N in ARB_IDLE gives gnt at N+1. The first accept is at N+1.
- Handover: always exactly one bubble cycle (ARB_IDLE) between owners.
- accept, mem_en, mem_we, mem_addr and mem_wdata are combinational from the registered state/owner and the owner's inputs.
- Read data path: rvalid is registered; rdata passes mem_rdata through.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- Simultaneous requests: exactly one grant. A requester dropping req in the same cycle as arbitration is not granted.

## Structure
- Package frame_mem_pkg holds:
  - arb_state_t enum logic {ARB_IDLE, ARB_GRANT}
  - default parameter constants shared with the stage engines
- Sub-module rr_picker (combinational): inputs req and rr_ptr; outputs valid and winner index.

## Test plan
- Single requester: req[2]=1 with reads at addresses 0x0010..0x0013 → gnt=5'b00100 one cycle later. rvalid[2] arrives one cycle after each accept with RAM contents. Release after req[2] drops.
- Burst cap, MAX_BURST=4: req[0] held high with writes → exactly 4 accepts, gnt low for one cycle, then re-granted to engine 0 (sole requester).
- Fairness: req=5'b11111 held continuously → grant order 0,1,2,3,4,0, each for MAX_BURST accepts, with one bubble between owners.
- Read at release: owner issues a read on its MAX_BURST-th accept → rvalid[owner] is still asserted the next cycle while gnt=0.
- enable low mid-burst: the burst completes, then no grant while enable=0 despite req=5'b01000. Grant follows one cycle after enable returns to 1.
- Async reset asserted mid-burst → gnt, mem_en and rvalid are 0 immediately. After reset, req=5'b00011 grants engine 0 first (rr_ptr=0).
